// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants, ALU operation codes, sequencer state encoding
// and the bundled control-strobe word shared by the control sequencer and
// its decoder.
package cpu_pkg;

  // Instruction opcodes, taken from IRout[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation codes; ALU_NONE is driven whenever the ALU is idle
  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;

  // Sequencer states; the numeric value is what appears on the step port
  typedef enum logic [3:0] {
    ST_T0   = 4'd0,
    ST_T1   = 4'd1,
    ST_T2   = 4'd2,
    ST_T3   = 4'd3,
    ST_T4   = 4'd4,
    ST_T5   = 4'd5,
    ST_T6   = 4'd6,
    ST_T7   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  // Every datapath control produced in one cycle
  typedef struct packed {
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       baOut;
    logic       pcOut;
    logic       pcIn;
    logic       incPc;
    logic       marIn;
    logic       mdrIn;
    logic       mdrOut;
    logic       irIn;
    logic       yIn;
    logic       zIn;
    logic       zLowOut;
    logic       cOut;
    logic       read;
    logic       write;
    logic [4:0] aluOp;
  } ctrl_t;

  // Three-register ALU instructions: Ra <= Rb op Rc
  function automatic logic isRegAlu(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // Instructions that form Rb (or 0 via BAout) plus the constant field
  function automatic logic isImmForm(input logic [4:0] op);
    return (op == OP_ADDI) || (op == OP_LDI) || (op == OP_LD) || (op == OP_ST);
  endfunction

  // Instructions that continue into a memory access after the address add
  function automatic logic isMemForm(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  // ALU code used in the execute cycle; immediate and address forms add
  function automatic logic [4:0] aluFor(input logic [4:0] op);
    logic [4:0] code;
    case (op)
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seq_decode.sv
// seq_decode: pure combinational Moore decode of the sequencer state and
// latched opcode into the datapath strobes and ALU operation code.
module seq_decode
  import cpu_pkg::*;
(
  input  state_e     state_i,
  input  logic [4:0] opcode_i,
  input  logic       firstT1_i,
  output ctrl_t      ctrl_o
);

  // Everything defaults low; each state raises only its own strobes
  always_comb begin
    ctrl_o       = '0;
    ctrl_o.aluOp = ALU_NONE;
    unique case (state_i)
      ST_T0: begin
        ctrl_o.pcOut = 1'b1;
        ctrl_o.marIn = 1'b1;
        ctrl_o.incPc = 1'b1;
        ctrl_o.zIn   = 1'b1;
      end
      ST_T1: begin
        ctrl_o.zLowOut = 1'b1;
        ctrl_o.pcIn    = firstT1_i;
        ctrl_o.read    = 1'b1;
        ctrl_o.mdrIn   = 1'b1;
      end
      ST_T2: begin
        ctrl_o.mdrOut = 1'b1;
        ctrl_o.irIn   = 1'b1;
      end
      ST_T3: begin
        if (isRegAlu(opcode_i)) begin
          ctrl_o.grb  = 1'b1;
          ctrl_o.rout = 1'b1;
          ctrl_o.yIn  = 1'b1;
        end else if (isImmForm(opcode_i)) begin
          ctrl_o.grb   = 1'b1;
          ctrl_o.rout  = 1'b1;
          ctrl_o.baOut = 1'b1;
          ctrl_o.yIn   = 1'b1;
        end
      end
      ST_T4: begin
        if (isRegAlu(opcode_i)) begin
          ctrl_o.grc   = 1'b1;
          ctrl_o.rout  = 1'b1;
          ctrl_o.zIn   = 1'b1;
          ctrl_o.aluOp = aluFor(opcode_i);
        end else if (isImmForm(opcode_i)) begin
          ctrl_o.cOut  = 1'b1;
          ctrl_o.zIn   = 1'b1;
          ctrl_o.aluOp = aluFor(opcode_i);
        end
      end
      ST_T5: begin
        if (isMemForm(opcode_i)) begin
          ctrl_o.zLowOut = 1'b1;
          ctrl_o.marIn   = 1'b1;
        end else if (isRegAlu(opcode_i) || isImmForm(opcode_i)) begin
          ctrl_o.zLowOut = 1'b1;
          ctrl_o.gra     = 1'b1;
          ctrl_o.rin     = 1'b1;
        end
      end
      ST_T6: begin
        if (opcode_i == OP_LD) begin
          ctrl_o.read  = 1'b1;
          ctrl_o.mdrIn = 1'b1;
        end else if (opcode_i == OP_ST) begin
          ctrl_o.gra   = 1'b1;
          ctrl_o.rout  = 1'b1;
          ctrl_o.mdrIn = 1'b1;
        end
      end
      ST_T7: begin
        if (opcode_i == OP_LD) begin
          ctrl_o.mdrOut = 1'b1;
          ctrl_o.gra    = 1'b1;
          ctrl_o.rin    = 1'b1;
        end else if (opcode_i == OP_ST) begin
          ctrl_o.write = 1'b1;
        end
      end
      default: begin
        ctrl_o.aluOp = ALU_NONE;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore control unit stepping T0..T7 per instruction,
// with an absorbing HALT state. Holds the state register, the latched
// opcode and the next-state logic; strobes come from seq_decode.
// Build option: define SEQ_MEM_WAIT_EN to stretch T1, T6 (ld) and T7 (st)
// until mem_ready; otherwise each memory state lasts exactly one cycle.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IRout,
  input  logic        mem_ready,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic [3:0]  step
);

  state_e     state_q, state_d;
  logic [4:0] opcode_q, opcode_d;
  logic       t1Repeat_q, t1Repeat_d;
  logic       memDone;
  logic       unusedBits;
  ctrl_t      ctrl;

`ifdef SEQ_MEM_WAIT_EN
  assign memDone    = mem_ready;
  assign unusedBits = ^IRout[26:0];
`else
  assign memDone    = 1'b1;
  assign unusedBits = ^{IRout[26:0], mem_ready};
`endif

  // State, opcode and fetch-wait registers; clear wins from any state
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= ST_T0;
      opcode_q   <= OP_NOP;
      t1Repeat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      t1Repeat_q <= t1Repeat_d;
    end
  end

  // Next state, opcode capture at the end of T2 and T1 repeat tracking
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    t1Repeat_d = (state_q == ST_T1);
    unique case (state_q)
      ST_T0: state_d = ST_T1;
      ST_T1: begin
        if (memDone) begin
          state_d = ST_T2;
        end
      end
      ST_T2: begin
        state_d  = ST_T3;
        opcode_d = IRout[31:27];
      end
      ST_T3: begin
        if (isRegAlu(opcode_q) || isImmForm(opcode_q)) begin
          state_d = ST_T4;
        end else if (opcode_q == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_T0;
        end
      end
      ST_T4: state_d = ST_T5;
      ST_T5: begin
        if (isMemForm(opcode_q)) begin
          state_d = ST_T6;
        end else begin
          state_d = ST_T0;
        end
      end
      ST_T6: begin
        if ((opcode_q == OP_ST) || memDone) begin
          state_d = ST_T7;
        end
      end
      ST_T7: begin
        if ((opcode_q != OP_ST) || memDone) begin
          state_d = ST_T0;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_T0;
    endcase
  end

  seq_decode decodeInst (
    .state_i   (state_q),
    .opcode_i  (opcode_q),
    .firstT1_i (~t1Repeat_q),
    .ctrl_o    (ctrl)
  );

  assign Gra     = ctrl.gra;
  assign Grb     = ctrl.grb;
  assign Grc     = ctrl.grc;
  assign Rin     = ctrl.rin;
  assign Rout    = ctrl.rout;
  assign BAout   = ctrl.baOut;
  assign PCout   = ctrl.pcOut;
  assign PCin    = ctrl.pcIn;
  assign IncPC   = ctrl.incPc;
  assign MARin   = ctrl.marIn;
  assign MDRin   = ctrl.mdrIn;
  assign MDRout  = ctrl.mdrOut;
  assign IRin    = ctrl.irIn;
  assign Yin     = ctrl.yIn;
  assign Zin     = ctrl.zIn;
  assign Zlowout = ctrl.zLowOut;
  assign Cout    = ctrl.cOut;
  assign Read    = ctrl.read;
  assign Write   = ctrl.write;
  assign alu_op  = ctrl.aluOp;
  assign run     = (state_q != ST_HALT);
  assign step    = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed stimulus for control_sequencer with an
// instruction-level reference model and a per-cycle compare process.
// Follows SEQ_MEM_WAIT_EN the same way the design does.
module tb_control_sequencer;

  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;

  localparam logic [31:0] I_ADD   = 32'h18910000;
  localparam logic [31:0] I_SUB   = 32'h20000000;
  localparam logic [31:0] I_AND   = 32'h28000000;
  localparam logic [31:0] I_OR    = 32'h30000000;
  localparam logic [31:0] I_ADDI  = 32'h60000000;
  localparam logic [31:0] I_LDI   = 32'h08000000;
  localparam logic [31:0] I_LD    = 32'h00800005;
  localparam logic [31:0] I_ST    = 32'h11000004;
  localparam logic [31:0] I_NOP   = 32'hD0000000;
  localparam logic [31:0] I_HALT  = 32'hD8000000;
  localparam logic [31:0] I_UNDEF = 32'hF8000000;

  localparam logic [18:0] GRA     = 19'd1;
  localparam logic [18:0] GRB     = 19'd2;
  localparam logic [18:0] GRC     = 19'd4;
  localparam logic [18:0] RIN     = 19'd8;
  localparam logic [18:0] ROUT    = 19'd16;
  localparam logic [18:0] BAOUT   = 19'd32;
  localparam logic [18:0] PCOUT   = 19'd64;
  localparam logic [18:0] PCIN    = 19'd128;
  localparam logic [18:0] INCPC   = 19'd256;
  localparam logic [18:0] MARIN   = 19'd512;
  localparam logic [18:0] MDRIN   = 19'd1024;
  localparam logic [18:0] MDROUT  = 19'd2048;
  localparam logic [18:0] IRIN    = 19'd4096;
  localparam logic [18:0] YIN     = 19'd8192;
  localparam logic [18:0] ZIN     = 19'd16384;
  localparam logic [18:0] ZLOWOUT = 19'd32768;
  localparam logic [18:0] COUT    = 19'd65536;
  localparam logic [18:0] READ    = 19'd131072;
  localparam logic [18:0] WRITE   = 19'd262144;

`ifdef SEQ_MEM_WAIT_EN
  localparam bit MEM_WAIT_EN = 1'b1;
`else
  localparam bit MEM_WAIT_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] IRout;
  logic        mem_ready;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Cout, Read, Write;
  logic [4:0]  alu_op;
  logic        run;
  logic [3:0]  step;
  logic [18:0] dutMask;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    int         stepNo;
    logic [18:0] mask;
    logic [4:0] alu;
    bit         waits;
  } micro_t;

  micro_t     prog[$];
  int         idx        = 0;
  bit         firstCyc   = 1'b1;
  bit         halted     = 1'b0;
  bit         modelValid = 1'b0;
  logic [4:0] mOp        = OP_NOP;

  control_sequencer dut (
    .clock     (clock),
    .clear     (clear),
    .IRout     (IRout),
    .mem_ready (mem_ready),
    .Gra       (Gra),
    .Grb       (Grb),
    .Grc       (Grc),
    .Rin       (Rin),
    .Rout      (Rout),
    .BAout     (BAout),
    .PCout     (PCout),
    .PCin      (PCin),
    .IncPC     (IncPC),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .MDRout    (MDRout),
    .IRin      (IRin),
    .Yin       (Yin),
    .Zin       (Zin),
    .Zlowout   (Zlowout),
    .Cout      (Cout),
    .Read      (Read),
    .Write     (Write),
    .alu_op    (alu_op),
    .run       (run),
    .step      (step)
  );

  assign dutMask = {Write, Read, Cout, Zlowout, Zin, Yin, IRin, MDRout, MDRin,
                    MARin, IncPC, PCin, PCout, BAout, Rout, Rin, Grc, Grb, Gra};

  // Free-running 10 ns clock
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic clr, input logic [31:0] ir, input logic mr);
    clear     = clr;
    IRout     = ir;
    mem_ready = mr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pushMicro(input int s, input logic [18:0] m, input logic [4:0] a,
                           input bit w);
    micro_t e;
    e.stepNo = s;
    e.mask   = m;
    e.alu    = a;
    e.waits  = w;
    prog.push_back(e);
  endtask

  // Instruction fetch: PC to MAR and increment, read memory, load IR
  task automatic loadFetch();
    prog.delete();
    pushMicro(0, PCOUT | MARIN | INCPC | ZIN, 5'd0, 1'b0);
    pushMicro(1, ZLOWOUT | PCIN | READ | MDRIN, 5'd0, 1'b1);
    pushMicro(2, MDROUT | IRIN, 5'd0, 1'b0);
    idx      = 0;
    firstCyc = 1'b1;
  endtask

  // Execute microprogram of one instruction, written as register transfers
  task automatic appendExec(input logic [4:0] op);
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR) begin
      pushMicro(3, GRB | ROUT | YIN, 5'd0, 1'b0);
      pushMicro(4, GRC | ROUT | ZIN, op, 1'b0);
      pushMicro(5, ZLOWOUT | GRA | RIN, 5'd0, 1'b0);
    end else if (op == OP_ADDI || op == OP_LDI || op == OP_LD || op == OP_ST) begin
      pushMicro(3, GRB | ROUT | BAOUT | YIN, 5'd0, 1'b0);
      pushMicro(4, COUT | ZIN, OP_ADD, 1'b0);
      if (op == OP_LD) begin
        pushMicro(5, ZLOWOUT | MARIN, 5'd0, 1'b0);
        pushMicro(6, READ | MDRIN, 5'd0, 1'b1);
        pushMicro(7, MDROUT | GRA | RIN, 5'd0, 1'b0);
      end else if (op == OP_ST) begin
        pushMicro(5, ZLOWOUT | MARIN, 5'd0, 1'b0);
        pushMicro(6, GRA | ROUT | MDRIN, 5'd0, 1'b0);
        pushMicro(7, WRITE, 5'd0, 1'b1);
      end else begin
        pushMicro(5, ZLOWOUT | GRA | RIN, 5'd0, 1'b0);
      end
    end else begin
      pushMicro(3, 19'd0, 5'd0, 1'b0);
    end
  endtask

  // Reference model: advance through the instruction's micro-steps per edge
  initial begin : modelProc
    forever begin
      @(posedge clock);
      if (clear === 1'b1) begin
        halted     = 1'b0;
        mOp        = OP_NOP;
        modelValid = 1'b1;
        loadFetch();
      end else if (modelValid && !halted) begin
        if (prog[idx].waits && MEM_WAIT_EN && (mem_ready !== 1'b1)) begin
          firstCyc = 1'b0;
        end else begin
          if (prog[idx].stepNo == 2) begin
            mOp = IRout[31:27];
            appendExec(mOp);
          end
          idx++;
          firstCyc = 1'b1;
          if (idx >= prog.size()) begin
            if (mOp == OP_HALT) halted = 1'b1;
            else loadFetch();
          end
        end
      end
    end
  end

  // Per-cycle compare of every output against the model
  initial begin : compareProc
    logic [18:0] expMask;
    int          expStep;
    logic [4:0]  expAlu;
    logic        expRun;
    forever begin
      @(negedge clock);
      if (modelValid) begin
        if (halted) begin
          expStep = 8;
          expMask = 19'd0;
          expAlu  = 5'd0;
          expRun  = 1'b0;
        end else begin
          expStep = prog[idx].stepNo;
          expMask = prog[idx].mask;
          if (expStep == 1 && !firstCyc) expMask = expMask & ~PCIN;
          expAlu  = prog[idx].alu;
          expRun  = 1'b1;
        end
        checkOutput("cycleStep", 32'(step), 32'(expStep));
        checkOutput("cycleStrobes", 32'(dutMask), 32'(expMask));
        checkOutput("cycleAluOp", 32'(alu_op), 32'(expAlu));
        checkOutput("cycleRun", 32'(run), 32'(expRun));
        checkOutput("readWriteExclusive", 32'(Read & Write), 32'd0);
        checkOutput("rinRoutExclusive", 32'(Rin & Rout), 32'd0);
      end
    end
  end

  task automatic waitForStep(input string name, input int target);
    int n = 0;
    while (step !== 4'(target) && n < 40) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(step), 32'(target));
  endtask

  task automatic measureLatency(input string name, input logic [31:0] ir,
                                input logic mr, input int expected);
    int cycles = 0;
    applyStimulus(1'b0, ir, mr);
    do begin
      tick();
      cycles++;
    end while (step !== 4'd0 && cycles < 60);
    checkOutput(name, 32'(cycles), 32'(expected));
  endtask

  // Hard stop in case anything wedges the simulation
  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected summary before timeout");
    $fatal(1, "[TB] simulation timeout");
  end

  // Directed scenarios with hand-computed expectations
  initial begin : stimulus
    int cycles;
    bit readLate, sawT6, sawT7;

    applyStimulus(1'b1, I_ADD, 1'b1);
    tick();
    checkOutput("resetStep", 32'(step), 32'd0);
    checkOutput("resetRun", 32'(run), 32'd1);
    checkOutput("resetPCout", 32'(PCout), 32'd1);
    checkOutput("resetIncPC", 32'(IncPC), 32'd1);
    checkOutput("resetRead", 32'(Read), 32'd0);
    checkOutput("resetOpcode", 32'(dut.opcode_q), 32'(OP_NOP));

    applyStimulus(1'b0, I_ADD, 1'b1);
    tick();
    checkOutput("addT1Step", 32'(step), 32'd1);
    checkOutput("addT1PCin", 32'(PCin), 32'd1);
    tick();
    checkOutput("addT2IRin", 32'(IRin), 32'd1);
    tick();
    checkOutput("addT3Yin", 32'(Yin), 32'd1);
    tick();
    checkOutput("addT4AluOp", 32'(alu_op), 32'h3);
    tick();
    checkOutput("addT5Step", 32'(step), 32'd5);
    checkOutput("addT5Zlowout", 32'(Zlowout), 32'd1);
    checkOutput("addT5Gra", 32'(Gra), 32'd1);
    checkOutput("addT5Rin", 32'(Rin), 32'd1);
    tick();
    checkOutput("addBackToT0", 32'(step), 32'd0);

    measureLatency("subLatency", I_SUB, 1'b1, 6);
    measureLatency("andLatency", I_AND, 1'b1, 6);
    measureLatency("orLatency", I_OR, 1'b1, 6);
    measureLatency("addiLatency", I_ADDI, 1'b1, 6);
    measureLatency("ldiLatency", I_LDI, 1'b1, 6);
    measureLatency("nopLatency", I_NOP, 1'b1, 4);

`ifdef SEQ_MEM_WAIT_EN
    applyStimulus(1'b0, I_ADD, 1'b0);
    tick();
    checkOutput("t1WaitFirstPCin", 32'(PCin), 32'd1);
    tick();
    checkOutput("t1WaitHeldStep", 32'(step), 32'd1);
    checkOutput("t1WaitHeldPCin", 32'(PCin), 32'd0);
    applyStimulus(1'b0, I_ADD, 1'b1);
    tick();
    checkOutput("t1WaitRelease", 32'(step), 32'd2);
    waitForStep("t1WaitDone", 0);
`endif

    applyStimulus(1'b0, I_LD, 1'b1);
    waitForStep("ldReachT6", 6);
    checkOutput("ldT6Read", 32'(Read), 32'd1);
    checkOutput("ldT6MDRin", 32'(MDRin), 32'd1);
`ifdef SEQ_MEM_WAIT_EN
    applyStimulus(1'b0, I_LD, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("ldT6HeldStep", 32'(step), 32'd6);
      checkOutput("ldT6HeldRead", 32'(Read), 32'd1);
      checkOutput("ldT6HeldMDRin", 32'(MDRin), 32'd1);
    end
    applyStimulus(1'b0, I_LD, 1'b1);
`endif
    tick();
    checkOutput("ldT7Step", 32'(step), 32'd7);
    checkOutput("ldT7Gra", 32'(Gra), 32'd1);
    checkOutput("ldT7Rin", 32'(Rin), 32'd1);
    tick();
    checkOutput("ldBackToT0", 32'(step), 32'd0);

`ifdef SEQ_MEM_WAIT_EN
    measureLatency("ldLatency", I_LD, 1'b1, 8);
`else
    measureLatency("ldLatencyNoReady", I_LD, 1'b0, 8);
`endif
    measureLatency("stLatency", I_ST, 1'b1, 8);

    applyStimulus(1'b0, I_ST, 1'b1);
    cycles   = 0;
    readLate = 1'b0;
    sawT6    = 1'b0;
    sawT7    = 1'b0;
    do begin
      tick();
      cycles++;
      if (step >= 4'd2 && step <= 4'd7 && Read) readLate = 1'b1;
      if (step == 4'd6) begin
        sawT6 = 1'b1;
        checkOutput("stT6Gra", 32'(Gra), 32'd1);
        checkOutput("stT6Rout", 32'(Rout), 32'd1);
        checkOutput("stT6MDRin", 32'(MDRin), 32'd1);
      end
      if (step == 4'd7) begin
        sawT7 = 1'b1;
        checkOutput("stT7Write", 32'(Write), 32'd1);
      end
    end while (step !== 4'd0 && cycles < 40);
    checkOutput("stSawT6", 32'(sawT6), 32'd1);
    checkOutput("stSawT7", 32'(sawT7), 32'd1);
    checkOutput("stNoLateRead", 32'(readLate), 32'd0);

    applyStimulus(1'b0, I_UNDEF, 1'b1);
    waitForStep("undefReachT3", 3);
    checkOutput("undefT3Strobes", 32'(dutMask), 32'd0);
    tick();
    checkOutput("undefBackToT0", 32'(step), 32'd0);

    applyStimulus(1'b0, I_LD, 1'b1);
    waitForStep("clrLdReachT6", 6);
`ifdef SEQ_MEM_WAIT_EN
    applyStimulus(1'b0, I_LD, 1'b0);
    tick();
    checkOutput("clrLdStillT6", 32'(step), 32'd6);
`endif
    applyStimulus(1'b1, I_LD, 1'b0);
    tick();
    checkOutput("clrMidT6Step", 32'(step), 32'd0);
    checkOutput("clrMidT6Read", 32'(Read), 32'd0);
    checkOutput("clrMidT6Opcode", 32'(dut.opcode_q), 32'(OP_NOP));
    checkOutput("clrMidT6Run", 32'(run), 32'd1);

    applyStimulus(1'b0, I_HALT, 1'b1);
    waitForStep("haltReachT3", 3);
    checkOutput("haltT3Strobes", 32'(dutMask), 32'd0);
    tick();
    checkOutput("haltStep", 32'(step), 32'd8);
    checkOutput("haltRun", 32'(run), 32'd0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, I_ADD, 1'(i % 2));
      tick();
      checkOutput("haltHeldRun", 32'(run), 32'd0);
      checkOutput("haltHeldStrobes", 32'(dutMask), 32'd0);
    end
    applyStimulus(1'b1, I_ADD, 1'b1);
    tick();
    checkOutput("haltClearStep", 32'(step), 32'd0);
    checkOutput("haltClearRun", 32'(run), 32'd1);
    measureLatency("postHaltAdd", I_ADD, 1'b1, 6);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
